rcs_seq_addsub: RTL and testbench

- Parametrised, multi-cycle add/subtract unit; successor to the fixed-width ripple-carry subtractors.
- Processes one CHUNK-bit slice per clock, least significant slice first, with a registered carry between slices. This trades latency for a short carry path.
- Adds a mode input (add/sub), a start/busy/done handshake, carry-in for add, and signed-overflow detection.
- Used by datapaths that need wide arithmetic at high clock rates.

---
 rtl/rcs_seq_addsub_pkg.sv | 22 ++
 rtl/rcs_seq_addsub_chunk.sv | 29 ++
 rtl/rcs_seq_addsub.sv | 128 ++++++++++++
 tb/tb_rcs_seq_addsub.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/rcs_seq_addsub_pkg.sv
// Shared definitions for the sequential chunked add/subtract unit:
// FSM encoding, mode constants and chunk-count helpers.
package rcs_seq_addsub_pkg;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    function automatic int nchunk_f(input int width, input int chunk);
        return width / chunk;
    endfunction

    // Index counter width; never narrower than one bit, even for a single chunk.
    function automatic int idx_w_f(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rcs_seq_addsub_chunk.sv
// Combinational CHUNK-bit ripple adder slice; also exposes the carry into
// its MSB so the top level can form signed overflow from the last slice.
module rcs_chunk #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a_i,
    input  logic [CHUNK-1:0] b_i,
    input  logic             cin_i,
    output logic [CHUNK-1:0] s_o,
    output logic             cout_o,
    output logic             cmsb_o
);

    logic [CHUNK:0] c;

    always_comb begin
        c    = '0;
        s_o  = '0;
        c[0] = cin_i;
        for (int i = 0; i < CHUNK; i++) begin
            s_o[i]  = a_i[i] ^ b_i[i] ^ c[i];
            c[i+1]  = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
        end
    end

    assign cout_o = c[CHUNK];
    assign cmsb_o = c[CHUNK-1];

endmodule

// File: rtl/rcs_seq_addsub.sv
// Multi-cycle add/subtract: one CHUNK-bit slice per clock, LSB slice first,
// with the inter-slice carry held in a register to keep the carry path short.
module rcs_seq_addsub
    import rcs_seq_addsub_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow
);

    localparam int NCHUNK = nchunk_f(WIDTH, CHUNK);
    localparam int IDXW   = idx_w_f(NCHUNK);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

    if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_cfg
        $error("rcs_seq_addsub: WIDTH must be a positive multiple of CHUNK");
    end

    state_e           state_q, state_d;
    logic [IDXW-1:0]  idx_q;
    logic             carry_q;
    logic             done_q;
    logic             cout_q;
    logic             ovf_q;
    logic [WIDTH-1:0] sum_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;

    logic             accept;
    logic             step;
    logic             last;
    logic [CHUNK-1:0] a_sl, b_sl, s_sl;
    logic             c_sl, cmsb_sl;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (idx_q == LAST_IDX) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy   = (state_q == S_RUN);
        accept = (state_q == S_IDLE) && start;
        step   = (state_q == S_RUN);
        last   = step && (idx_q == LAST_IDX);
    end

    always_comb begin
        a_sl = '0;
        b_sl = '0;
        for (int i = 0; i < NCHUNK; i++) begin
            if (idx_q == IDXW'(i)) begin
                a_sl = a_q[i*CHUNK +: CHUNK];
                b_sl = b_q[i*CHUNK +: CHUNK];
            end
        end
    end

    rcs_chunk #(.CHUNK(CHUNK)) u_chunk (
        .a_i    (a_sl),
        .b_i    (b_sl),
        .cin_i  (carry_q),
        .s_o    (s_sl),
        .cout_o (c_sl),
        .cmsb_o (cmsb_sl)
    );

    // Subtraction is folded in at accept time: B is stored inverted and the carry forced to 1.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_q <= a;
            b_q <= (mode == MODE_SUB) ? ~b : b;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q   <= '0;
            carry_q <= 1'b0;
            done_q  <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            sum_q   <= '0;
        end else begin
            done_q <= last;
            if (accept) begin
                idx_q   <= '0;
                carry_q <= (mode == MODE_SUB) ? 1'b1 : carry_in;
            end else if (step) begin
                idx_q   <= last ? '0 : idx_q + 1'b1;
                carry_q <= c_sl;
                for (int i = 0; i < NCHUNK; i++) begin
                    if (idx_q == IDXW'(i)) sum_q[i*CHUNK +: CHUNK] <= s_sl;
                end
                if (last) begin
                    cout_q <= c_sl;
                    ovf_q  <= c_sl ^ cmsb_sl;
                end
            end
        end
    end

    assign done      = done_q;
    assign sum       = sum_q;
    assign carry_out = cout_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_rcs_seq_addsub.sv
// Scoreboard bench for rcs_seq_addsub: a 32/8 instance and a 16/16 single-chunk instance.
module tb_rcs_seq_addsub;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start, mode, carry_in;
    logic [31:0] a, b;
    logic        busy, done, carry_out, overflow;
    logic [31:0] sum;

    logic        s_start, s_mode, s_cin;
    logic [15:0] s_a, s_b;
    logic        s_busy, s_done, s_cout, s_ovf;
    logic [15:0] s_sum;

    rcs_seq_addsub #(.WIDTH(32), .CHUNK(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .a(a), .b(b),
        .carry_in(carry_in), .busy(busy), .done(done), .sum(sum),
        .carry_out(carry_out), .overflow(overflow)
    );

    rcs_seq_addsub #(.WIDTH(16), .CHUNK(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(s_start), .mode(s_mode), .a(s_a), .b(s_b),
        .carry_in(s_cin), .busy(s_busy), .done(s_done), .sum(s_sum),
        .carry_out(s_cout), .overflow(s_ovf)
    );

    typedef struct {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        int          acc;
    } exp_t;

    exp_t q32[$];
    exp_t q16[$];
    exp_t e32, e16;
    int   cyc    = 0;
    int   n_chk  = 0;
    int   n_pass = 0;
    int   bc32   = 0;
    int   bc16   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    endtask

    // Monitor for the 32-bit instance
    always @(negedge clk) begin
        if (!rst_n) bc32 = 0;
        else begin
            if (busy) bc32++;
            if (done) begin
                chk("done32_expected", 32'(q32.size() != 0), 32'd1);
                if (q32.size() != 0) begin
                    e32 = q32.pop_front();
                    chk("sum32", sum, e32.sum);
                    chk("cout32", 32'(carry_out), 32'(e32.cout));
                    chk("ovf32", 32'(overflow), 32'(e32.ovf));
                    chk("latency32", 32'(cyc - e32.acc), 32'd4);
                    chk("busy_cycles32", 32'(bc32), 32'd4);
                end
                chk("done32_not_busy", 32'(busy), 32'd0);
                bc32 = 0;
            end
        end
    end

    // Monitor for the single-chunk instance
    always @(negedge clk) begin
        if (!rst_n) bc16 = 0;
        else begin
            if (s_busy) bc16++;
            if (s_done) begin
                chk("done16_expected", 32'(q16.size() != 0), 32'd1);
                if (q16.size() != 0) begin
                    e16 = q16.pop_front();
                    chk("sum16", 32'(s_sum), e16.sum);
                    chk("cout16", 32'(s_cout), 32'(e16.cout));
                    chk("ovf16", 32'(s_ovf), 32'(e16.ovf));
                    chk("latency16", 32'(cyc - e16.acc), 32'd1);
                    chk("busy_cycles16", 32'(bc16), 32'd1);
                end
                chk("done16_not_busy", 32'(s_busy), 32'd0);
                bc16 = 0;
            end
        end
    end

    task automatic op32(input logic m, input logic [31:0] av, input logic [31:0] bv,
                        input logic ci, input bit track,
                        input logic [31:0] es, input logic ec, input logic eo);
        start = 1'b1; mode = m; a = av; b = bv; carry_in = ci;
        @(posedge clk); #1;
        if (track) q32.push_back('{sum: es, cout: ec, ovf: eo, acc: cyc});
        start = 1'b0;
    endtask

    task automatic op16(input logic m, input logic [15:0] av, input logic [15:0] bv,
                        input logic ci, input logic [15:0] es, input logic ec, input logic eo);
        s_start = 1'b1; s_mode = m; s_a = av; s_b = bv; s_cin = ci;
        @(posedge clk); #1;
        q16.push_back('{sum: 32'(es), cout: ec, ovf: eo, acc: cyc});
        s_start = 1'b0;
    endtask

    task automatic wait_done32();
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (done) break;
        end
        chk("done32_timeout", 32'(done), 32'd1);
    endtask

    task automatic wait_done16();
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (s_done) break;
        end
        chk("done16_timeout", 32'(s_done), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, n_chk=%0d", n_chk);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        start = 1'b0; mode = 1'b0; carry_in = 1'b0; a = '0; b = '0;
        s_start = 1'b0; s_mode = 1'b0; s_cin = 1'b0; s_a = '0; s_b = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_sum", sum, 32'd0);
        chk("rst_cout", 32'(carry_out), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        op32(1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1, 32'h0000_0000, 1'b1, 1'b0);
        wait_done32();
        @(negedge clk);
        op32(1'b1, 32'h0000_0005, 32'h0000_0007, 1'b1, 1, 32'hFFFF_FFFE, 1'b0, 1'b0);
        wait_done32();
        @(negedge clk);
        op32(1'b1, 32'h8000_0000, 32'h0000_0001, 1'b0, 1, 32'h7FFF_FFFF, 1'b1, 1'b1);
        wait_done32();
        @(negedge clk);
        op32(1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1, 32'h8000_0000, 1'b0, 1'b1);
        wait_done32();
        @(negedge clk);
        op32(1'b1, 32'h1234_ABCD, 32'h1234_ABCD, 1'b0, 1, 32'h0000_0000, 1'b1, 1'b0);
        wait_done32();

        // A start pulse mid-operation (with changed mode/carry_in) must be ignored
        @(negedge clk);
        op32(1'b0, 32'h0000_0010, 32'h0000_0020, 1'b0, 1, 32'h0000_0030, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        start = 1'b1; a = 32'hFF; b = 32'hFF; mode = 1'b1; carry_in = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done32();
        op32(1'b0, 32'h0000_00FF, 32'h0000_00FF, 1'b0, 1, 32'h0000_01FE, 1'b0, 1'b0);
        wait_done32();
        repeat (3) @(negedge clk);
        chk("sum_hold", sum, 32'h0000_01FE);

        // Abort mid-operation via reset; the aborted op must never produce done
        op32(1'b0, 32'h1234_5678, 32'h0000_0001, 1'b0, 0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_sum", sum, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        op32(1'b0, 32'h1234_5678, 32'h1111_1111, 1'b1, 1, 32'h2345_678A, 1'b0, 1'b0);
        wait_done32();

        @(negedge clk);
        op16(1'b1, 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b0, 1'b0);
        wait_done16();
        @(negedge clk);
        op16(1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        wait_done16();

        repeat (5) @(negedge clk);
        chk("q32_drained", 32'(q32.size()), 32'd0);
        chk("q16_drained", 32'(q16.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
